// File: rtl/imm_extend_stage.sv
// Immediate extension stage: widens a raw immediate by mode and buffers
// results in a two-entry FIFO with valid/ready handshakes on both sides.
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IN_W-1:0]  I,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] O,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] acc_cnt
);

    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] head;
    logic [OUT_W-1:0] tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign sx = {{PAD{I[IN_W-1]}}, I};

    always_comb begin
        ext = '0;
        unique case (mode)
            2'b00: ext = {{PAD{1'b0}}, I};
            2'b01: ext = sx;
            2'b10: ext = {I, {PAD{1'b0}}};
            2'b11: ext = {sx[OUT_W-3:0], 2'b00};
        endcase
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign O         = out_valid ? head : '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Push and pop together only happen at count 1, so the new item becomes head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= ext;
                    else               tail <= ext;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: head <= ext;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    acc_cnt <= '0;
        else if (push) acc_cnt <= acc_cnt + 1'b1;
    end

endmodule
